byte_serial_adder_ctrl: RTL and testbench

Sequential front-end for the combinational 8-bit `conditional_sum_adder`. Accepts a byte stream of operand pairs, least-significant byte first, over a valid/ready handshake. Chains carry across beats so multi-byte operands are added 8 bits per cycle, and registers each sum byte onto a valid/ready output stream. On the last beat it reports the final carry and signed overflow.

---
 rtl/adder_pkg.sv | 16 +
 rtl/byte_serial_adder_ctrl_if.sv | 38 +++
 rtl/conditional_sum_adder.sv | 32 +++
 rtl/byte_serial_adder_ctrl.sv | 130 +++++++++++++
 tb/tb_byte_serial_adder_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// adder_pkg : shared byte width and control-FSM state encoding
// Rev 1.0
// ============================================================================
package adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/byte_serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// byte_serial_adder_ctrl_if : operand-in / sum-out streams plus error status
// Rev 1.0
// ============================================================================
interface byte_serial_adder_ctrl_if;
    import adder_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] in_a;
    logic [BYTE_W-1:0] in_b;
    logic              in_first;
    logic              in_last;
    logic              in_cin;
    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] out_sum;
    logic              out_last;
    logic              out_cout;
    logic              out_ovf;
    logic              err;
    logic              err_clr;

    modport slave (
        input  in_valid, in_a, in_b, in_first, in_last, in_cin,
        input  out_ready, err_clr,
        output in_ready, out_valid, out_sum, out_last, out_cout, out_ovf, err
    );

    modport master (
        output in_valid, in_a, in_b, in_first, in_last, in_cin,
        output out_ready, err_clr,
        input  in_ready, out_valid, out_sum, out_last, out_cout, out_ovf, err
    );

endinterface
`default_nettype wire

// File: rtl/conditional_sum_adder.sv
`default_nettype none
// ============================================================================
// conditional_sum_adder : combinational byte adder, upper half pre-computed
// for both carry values and selected by the lower-half carry.  Rev 1.0
// ============================================================================
module conditional_sum_adder
    import adder_pkg::*;
(
    input  wire logic [BYTE_W-1:0] a,
    input  wire logic [BYTE_W-1:0] b,
    input  wire logic              cin,
    output logic      [BYTE_W-1:0] sum,
    output logic                   cout
);

    localparam int HALF_W = BYTE_W / 2;

    logic [HALF_W:0] w_lo;
    logic [HALF_W:0] w_hi0;
    logic [HALF_W:0] w_hi1;
    logic [HALF_W:0] w_hi;

    assign w_lo  = {1'b0, a[HALF_W-1:0]} + {1'b0, b[HALF_W-1:0]} + {{HALF_W{1'b0}}, cin};
    assign w_hi0 = {1'b0, a[BYTE_W-1:HALF_W]} + {1'b0, b[BYTE_W-1:HALF_W]};
    assign w_hi1 = w_hi0 + {{HALF_W{1'b0}}, 1'b1};
    assign w_hi  = w_lo[HALF_W] ? w_hi1 : w_hi0;

    assign sum  = {w_hi[HALF_W-1:0], w_lo[HALF_W-1:0]};
    assign cout = w_hi[HALF_W];

endmodule
`default_nettype wire

// File: rtl/byte_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// byte_serial_adder_ctrl : chains the byte adder across LS-first beats and
// registers each sum byte onto a valid/ready output stream.  Rev 1.0
// ============================================================================
module byte_serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int MAX_BEATS = 16
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    byte_serial_adder_ctrl_if.slave  bus
);

    localparam int                CNT_W   = $clog2(MAX_BEATS) + 1;
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BEATS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_carry;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_out_valid;
    logic [BYTE_W-1:0]   r_out_sum;
    logic                r_out_last;
    logic                r_out_cout;
    logic                r_out_ovf;
    logic                r_err;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_first_eff;
    logic                w_proto_err;
    logic                w_len_err;
    logic                w_last_eff;
    logic                w_cin;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [BYTE_W-1:0]   w_sum;
    logic                w_cout;
    logic                w_ovf;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    conditional_sum_adder u_adder (bus.in_a, bus.in_b, w_cin, w_sum, w_cout);

    assign w_ovf = (bus.in_a[BYTE_W-1] == bus.in_b[BYTE_W-1]) &&
                   (w_sum[BYTE_W-1] != bus.in_a[BYTE_W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A beat arriving with no packet open is always handled as a first beat.
    always_comb begin
        w_state_nxt = r_state;
        w_first_eff = 1'b0;
        w_proto_err = 1'b0;
        w_len_err   = 1'b0;
        w_last_eff  = 1'b0;
        w_cin       = r_carry;
        w_cnt_nxt   = r_cnt;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    w_first_eff = 1'b1;
                    w_proto_err = !bus.in_first;
                end
                BUSY: begin
                    w_first_eff = bus.in_first;
                    w_proto_err = bus.in_first;
                end
                default: begin
                    w_first_eff = 1'b1;
                end
            endcase
            w_cin       = w_first_eff ? bus.in_cin : r_carry;
            w_cnt_nxt   = w_first_eff ? CNT_W'(1) : r_cnt + CNT_W'(1);
            // A non-last beat filling the packet is closed here, since the next would overrun.
            w_len_err   = !bus.in_last && (w_cnt_nxt >= MAX_CNT);
            w_last_eff  = bus.in_last || w_len_err;
            w_state_nxt = w_last_eff ? IDLE : BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_last  <= 1'b0;
            r_out_cout  <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_carry     <= w_cout;
                r_cnt       <= w_cnt_nxt;
                r_out_valid <= 1'b1;
                r_out_sum   <= w_sum;
                r_out_last  <= w_last_eff;
                r_out_cout  <= w_last_eff && w_cout;
                r_out_ovf   <= w_last_eff && w_ovf;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_proto_err || w_len_err) begin
                r_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_last  = r_out_last;
    assign bus.out_cout  = r_out_cout;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_byte_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// tb_byte_serial_adder_ctrl : directed protocol cases, then random packets
// checked against a full-width arithmetic model.  Rev 1.0
// ============================================================================
module tb_byte_serial_adder_ctrl;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       first;
        logic       last;
        logic       cin;
    } beat_t;

    typedef struct packed {
        logic [7:0] sum;
        logic       last;
        logic       cout;
        logic       ovf;
    } res_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    byte_serial_adder_ctrl_if bus ();

    byte_serial_adder_ctrl #(.MAX_BEATS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] sum, input logic last,
                           input logic cout, input logic ovf);
        chk(tag, {bus.out_valid, bus.out_sum, bus.out_last, bus.out_cout, bus.out_ovf},
                 {1'b1, sum, last, cout, ovf});
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic first,
                         input logic last, input logic cin);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_first = first;
        bus.in_last  = last;
        bus.in_cin   = cin;
    endtask

    task automatic idle_in();
        bus.in_valid = 1'b0;
        bus.in_a     = 8'h00;
        bus.in_b     = 8'h00;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_cin   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    beat_t        bq[$];
    res_t         eq[$];
    logic [135:0] opa, opb, fsum;
    res_t         r;
    int           n, bi, ei, cyc;
    logic         pcin, povf;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        idle_in();
        bus.out_ready = 1'b1;
        bus.err_clr   = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("reset_state", {bus.out_valid, bus.out_sum, bus.out_last, bus.out_cout,
                            bus.out_ovf, bus.err, bus.in_ready},
                           {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        #19 rst_n = 1'b1;
        tick();

        // Single-beat packets
        drive(8'h01, 8'h03, 1, 1, 0); tick(); idle_in();
        chk_out("single_01_03", 8'h04, 1, 0, 0);
        tick();
        chk("retire_valid", bus.out_valid, 0);
        drive(8'h80, 8'h80, 1, 1, 0); tick(); idle_in();
        chk_out("single_80_80", 8'h00, 1, 1, 1);
        tick();

        // Two-beat back-to-back 0x01FF + 0x0001
        drive(8'hFF, 8'h01, 1, 0, 0); tick();
        chk_out("two_beat_b1", 8'h00, 0, 0, 0);
        drive(8'h01, 8'h00, 0, 1, 0); tick(); idle_in();
        chk_out("two_beat_b2", 8'h02, 1, 0, 0);
        tick();

        // Backpressure mid-packet
        drive(8'h10, 8'h20, 1, 0, 0); tick();
        chk_out("bp_b1", 8'h30, 0, 0, 0);
        bus.out_ready = 1'b0;
        drive(8'h40, 8'h50, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_hold", {bus.out_valid, bus.out_sum}, {1'b1, 8'h30});
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk_out("bp_b2", 8'h90, 0, 0, 0);
        drive(8'h01, 8'h02, 0, 1, 0); tick(); idle_in();
        chk_out("bp_b3", 8'h03, 1, 0, 0);
        tick();

        // First beat while a packet is open
        chk("err_before", bus.err, 0);
        drive(8'hFF, 8'h01, 1, 0, 0); tick();
        chk_out("busy_b1", 8'h00, 0, 0, 0);
        drive(8'h02, 8'h03, 1, 1, 0); tick(); idle_in();
        chk_out("busy_restart", 8'h05, 1, 0, 0);
        chk("err_first_in_busy", bus.err, 1);
        tick();
        bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
        chk("err_clr", bus.err, 0);

        // Overlong packet: 17 beats with no last
        for (int i = 0; i < 17; i++) begin
            drive(8'(i + 1), 8'h00, (i == 0), 0, 0); tick();
            chk_out("long_beat", 8'(i + 1), (i == 15), 0, 0);
            chk("long_err", bus.err, (i >= 15));
        end
        drive(8'h00, 8'h00, 0, 1, 0); tick(); idle_in();
        chk_out("long_close", 8'h00, 1, 0, 0);
        bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
        chk("long_err_clr", bus.err, 0);

        // Asynchronous reset mid-packet
        drive(8'hFF, 8'h01, 1, 0, 0); tick(); idle_in();
        chk_out("rst_mid_b1", 8'h00, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_async", {bus.out_valid, bus.out_sum, bus.out_last, bus.out_cout,
                              bus.out_ovf, bus.err, bus.in_ready},
                             {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        #2 rst_n = 1'b1;
        tick();
        drive(8'h05, 8'h06, 1, 1, 0); tick(); idle_in();
        chk_out("post_rst_05_06", 8'h0B, 1, 0, 0);
        tick();

        // Random packets against a full-width model
        for (int p = 0; p < 40; p++) begin
            n    = $urandom_range(1, 16);
            pcin = 1'($urandom_range(0, 1));
            opa  = '0;
            opb  = '0;
            for (int i = 0; i < n; i++) begin
                opa[8*i +: 8] = 8'($urandom);
                opb[8*i +: 8] = 8'($urandom);
                bq.push_back('{a: opa[8*i +: 8], b: opb[8*i +: 8], first: (i == 0),
                               last: (i == n - 1), cin: pcin});
            end
            fsum = opa + opb + 136'(pcin);
            povf = (opa[8*n-1] == opb[8*n-1]) && (fsum[8*n-1] != opa[8*n-1]);
            for (int i = 0; i < n; i++) begin
                r.sum  = fsum[8*i +: 8];
                r.last = (i == n - 1);
                r.cout = (i == n - 1) ? fsum[8*n] : 1'b0;
                r.ovf  = (i == n - 1) ? povf : 1'b0;
                eq.push_back(r);
            end
        end

        bi  = 0;
        ei  = 0;
        cyc = 0;
        while (ei < eq.size() && cyc < 5000) begin
            if (bi < bq.size() && $urandom_range(0, 3) != 0)
                drive(bq[bi].a, bq[bi].b, bq[bi].first, bq[bi].last, bq[bi].cin);
            else
                idle_in();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk("rand_in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid && bus.out_ready) begin
                chk("rand_out", {bus.out_sum, bus.out_last, bus.out_cout, bus.out_ovf}, eq[ei]);
                ei++;
            end
            if (bus.in_valid && bus.in_ready) bi++;
            tick();
            cyc++;
        end
        idle_in();
        bus.out_ready = 1'b1;
        chk("rand_all_outputs", ei, eq.size());
        chk("rand_no_err", bus.err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
